// File: rtl/a78_cart_loader.sv
// Download sequencer from the HPS ioctl byte stream into the 7800 cart/BIOS RAMs.
// Parses the A78 header, strips it from the cart image and reports the cart size.
module a78_cart_loader #(
  parameter int CART_AW = 18,
  parameter int BIOS_AW = 12,
  parameter int HDR_LEN = 128
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               ioctl_download,
  input  logic [7:0]         ioctl_index,
  input  logic               ioctl_wr,
  input  logic [24:0]        ioctl_addr,
  input  logic [7:0]         ioctl_dout,
  output logic               ioctl_wait,
  input  logic               mem_busy,
  output logic               cart_we,
  output logic               bios_we,
  output logic [CART_AW-1:0] mem_addr,
  output logic [7:0]         mem_data,
  output logic               cart_is_7800,
  output logic [15:0]        cart_flags,
  output logic [7:0]         joy0_type,
  output logic [7:0]         joy1_type,
  output logic [7:0]         cart_region,
  output logic [7:0]         cart_save,
  output logic [31:0]        cart_size,
  output logic               core_hold,
  output logic               load_done,
  output logic               drop_err
);

  typedef enum logic [1:0] {IDLE, CART, BIOS, FINISH} state_t;
  state_t state, state_nx;

  logic        we, loading, accept, drop_strobe, overflow;
  logic        cart_ok, bios_ok, write_cart, write_bios;
  logic        cart_dl, released, have_addr;
  logic [4:0]  atari_ok;
  logic [24:0] cart_addr, last_addr;
  logic [31:0] size_q, size_total, size_hdr, size_calc;

  assign we           = cart_we | bios_we;
  assign ioctl_wait   = we & mem_busy;
  assign loading      = (state == CART) || (state == BIOS);
  assign accept       = ioctl_wr & loading & ~ioctl_wait;
  assign drop_strobe  = ioctl_wr & loading & ioctl_wait;
  assign cart_is_7800 = &atari_ok;

  always_comb begin
    cart_addr = ioctl_addr;
    if (cart_is_7800 && (ioctl_addr >= 25'(HDR_LEN)))
      cart_addr = ioctl_addr - 25'(HDR_LEN);
  end

  assign cart_ok    = (cart_addr >> CART_AW) == '0;
  assign bios_ok    = (ioctl_addr >> BIOS_AW) == '0;
  assign write_cart = accept && (state == CART) && cart_ok;
  assign write_bios = accept && (state == BIOS) && bios_ok;
  assign overflow   = accept & ~write_cart & ~write_bios;

  always_comb begin
    size_total = {7'd0, last_addr} + 32'd1;
    size_hdr   = cart_is_7800 ? 32'(HDR_LEN) : '0;
    size_calc  = '0;
    if (have_addr && (size_total > size_hdr))
      size_calc = size_total - size_hdr;
  end

  // load_done fires on the first FINISH cycle with nothing in flight; cart_size
  // is bypassed in that cycle so the pulse and the new size appear together.
  assign load_done = (state == FINISH) && cart_dl && !we;
  assign cart_size = load_done ? size_calc : size_q;
  assign core_hold = ~released | (state == CART) | (state == FINISH);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (ioctl_download) state_nx = (ioctl_index != 8'd0) ? CART : BIOS;
      CART, BIOS: if (!ioctl_download) state_nx = FINISH;
      FINISH:     if (!we) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // Write port: a new accepted strobe may replace a write completing this cycle.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      cart_we  <= 1'b0;
      bios_we  <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      drop_err <= 1'b0;
    end else begin
      if (write_cart || write_bios) begin
        cart_we  <= write_cart;
        bios_we  <= write_bios;
        mem_addr <= write_cart ? cart_addr[CART_AW-1:0]
                               : CART_AW'(ioctl_addr[BIOS_AW-1:0]);
        mem_data <= ioctl_dout;
      end else if (we && !mem_busy) begin
        cart_we <= 1'b0;
        bios_we <= 1'b0;
      end
      if (drop_strobe || overflow)
        drop_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      cart_dl     <= 1'b0;
      released    <= 1'b0;
      have_addr   <= 1'b0;
      last_addr   <= '0;
      atari_ok    <= '0;
      cart_flags  <= '0;
      joy0_type   <= '0;
      joy1_type   <= '0;
      cart_region <= '0;
      cart_save   <= '0;
      size_q      <= '0;
    end else begin
      if (state == IDLE && ioctl_download) begin
        cart_dl <= (ioctl_index != 8'd0);
        if (ioctl_index != 8'd0) begin
          have_addr   <= 1'b0;
          atari_ok    <= '0;
          cart_flags  <= '0;
          joy0_type   <= '0;
          joy1_type   <= '0;
          cart_region <= '0;
          cart_save   <= '0;
        end
      end
      if (accept && state == CART) begin
        have_addr <= 1'b1;
        last_addr <= ioctl_addr;
        case (ioctl_addr)
          25'd1:   atari_ok[0]       <= (ioctl_dout == 8'h41);
          25'd2:   atari_ok[1]       <= (ioctl_dout == 8'h54);
          25'd3:   atari_ok[2]       <= (ioctl_dout == 8'h41);
          25'd4:   atari_ok[3]       <= (ioctl_dout == 8'h52);
          25'd5:   atari_ok[4]       <= (ioctl_dout == 8'h49);
          25'd53:  cart_flags[15:8]  <= ioctl_dout;
          25'd54:  cart_flags[7:0]   <= ioctl_dout;
          25'd55:  joy0_type         <= ioctl_dout;
          25'd56:  joy1_type         <= ioctl_dout;
          25'd57:  cart_region       <= ioctl_dout;
          25'd58:  cart_save         <= ioctl_dout;
          default: ;
        endcase
      end
      if (load_done) begin
        size_q   <= size_calc;
        released <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_a78_cart_loader.sv
// Randomized self-checking bench for a78_cart_loader: file images are modelled
// as byte queues and compared against the RAM writes observed on the port.
module tb_a78_cart_loader;
  localparam int CART_AW = 18;

  logic               clk_sys = 1'b0;
  logic               reset_n, ioctl_download, ioctl_wr, mem_busy;
  logic [7:0]         ioctl_index, ioctl_dout;
  logic [24:0]        ioctl_addr;
  logic               ioctl_wait, cart_we, bios_we, cart_is_7800, core_hold, load_done, drop_err;
  logic [CART_AW-1:0] mem_addr;
  logic [7:0]         mem_data, joy0_type, joy1_type, cart_region, cart_save;
  logic [15:0]        cart_flags;
  logic [31:0]        cart_size;

  int checks = 0, errors = 0;
  logic [7:0] cart_img [int];
  logic [7:0] bios_img [int];
  int cart_wr_cnt = 0, bios_wr_cnt = 0, load_cnt = 0;
  logic [31:0] last_size = '0;
  logic prev_stall = 1'b0, prev_cwe = 1'b0;
  logic [CART_AW-1:0] prev_addr = '0;
  logic [7:0] prev_data = '0;

  always #5 clk_sys = ~clk_sys;

  a78_cart_loader #(.CART_AW(CART_AW), .BIOS_AW(12), .HDR_LEN(128)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_busy(mem_busy),
    .cart_we(cart_we), .bios_we(bios_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .cart_is_7800(cart_is_7800), .cart_flags(cart_flags), .joy0_type(joy0_type),
    .joy1_type(joy1_type), .cart_region(cart_region), .cart_save(cart_save),
    .cart_size(cart_size), .core_hold(core_hold), .load_done(load_done), .drop_err(drop_err)
  );

  // Write port observer on the falling edge.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      checks++;
      if (ioctl_wait !== ((cart_we | bios_we) & mem_busy)) begin
        errors++;
        $display("FAIL wait_flag: got %b expected %b", ioctl_wait, (cart_we | bios_we) & mem_busy);
      end
      if (prev_stall) begin
        checks++;
        if (cart_we !== prev_cwe || bios_we !== !prev_cwe || mem_addr !== prev_addr || mem_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: got we=%b/%b addr=%h data=%h expected addr=%h data=%h",
                   cart_we, bios_we, mem_addr, mem_data, prev_addr, prev_data);
        end
      end
      if (cart_we && !mem_busy) begin cart_img[int'(mem_addr)] = mem_data; cart_wr_cnt++; end
      if (bios_we && !mem_busy) begin bios_img[int'(mem_addr[11:0])] = mem_data; bios_wr_cnt++; end
      if (load_done) begin load_cnt++; last_size = cart_size; end
      prev_stall = (cart_we | bios_we) & mem_busy;
      prev_cwe   = cart_we;
      prev_addr  = mem_addr;
      prev_data  = mem_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk_sys); #1;
  endtask

  function automatic logic ref_is7800(input logic [7:0] f[$]);
    string s = "ATARI";
    if (f.size() < 6) return 1'b0;
    for (int k = 0; k < 5; k++) if (f[1+k] != s[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_size(input int len, input logic is7800);
    int n = is7800 ? len - 128 : len;
    return (n < 0) ? 32'd0 : 32'(n);
  endfunction

  task automatic send_byte(input int a, input logic [7:0] d, input int pbusy);
    for (int n = 0; n < 200; n++) begin
      mem_busy = ($urandom_range(99) < pbusy);
      #1;
      if (!ioctl_wait) begin
        ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = d;
        cyc();
        ioctl_wr = 1'b0;
        return;
      end
      cyc();
    end
    checks++; errors++;
    $display("FAIL send_timeout: got ioctl_wait stuck high expected release for addr %0d", a);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx; ioctl_download = 1'b1;
    cyc();
  endtask

  task automatic end_dl();
    ioctl_wr = 1'b0; mem_busy = 1'b0; ioctl_download = 1'b0;
    repeat (6) cyc();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; mem_busy = 1'b0;
    ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0;
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    logic [31:0] exp_vec [9] = '{32'd1, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] got_vec [9];
    do_reset();
    got_vec = '{32'(core_hold), 32'(cart_we), 32'(bios_we), 32'(ioctl_wait), 32'(load_done),
                32'(drop_err), 32'(cart_is_7800), 32'(cart_flags), cart_size};
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got_vec[i] !== exp_vec[i]) begin
        errors++;
        $display("FAIL reset_value[%0d]: got %h expected %h", i, got_vec[i], exp_vec[i]);
      end
    end
    checks++;
    if ({joy0_type, joy1_type, cart_region, cart_save} !== 32'd0) begin
      errors++;
      $display("FAIL reset_hdr: got %h expected 0", {joy0_type, joy1_type, cart_region, cart_save});
    end
  endtask

  task automatic test_bios();
    int b_bios = bios_wr_cnt, b_cart = cart_wr_cnt, b_load = load_cnt, bad = 0;
    bios_img.delete();
    start_dl(8'd0);
    for (int a = 0; a < 4096; a++) begin
      logic [24:0] av = 25'(a);
      send_byte(a, av[7:0], 0);
    end
    checks++;
    if (core_hold !== 1'b1) begin errors++; $display("FAIL bios_hold_mid: got %b expected 1", core_hold); end
    end_dl();
    for (int a = 0; a < 4096; a++) begin
      logic [24:0] av = 25'(a);
      if (!bios_img.exists(a) || bios_img[a] !== av[7:0]) bad++;
    end
    checks++;
    if (bad !== 0 || bios_img.size() !== 4096) begin
      errors++; $display("FAIL bios_image: got %0d bad of %0d entries expected 0 bad of 4096", bad, bios_img.size());
    end
    checks++;
    if (bios_wr_cnt - b_bios !== 4096) begin
      errors++; $display("FAIL bios_count: got %0d expected 4096", bios_wr_cnt - b_bios);
    end
    checks++;
    if (cart_wr_cnt - b_cart !== 0 || load_cnt - b_load !== 0) begin
      errors++; $display("FAIL bios_side: got cart_wr=%0d load=%0d expected 0 0", cart_wr_cnt - b_cart, load_cnt - b_load);
    end
    checks++;
    if (core_hold !== 1'b1 || drop_err !== 1'b0) begin
      errors++; $display("FAIL bios_end: got hold=%b drop=%b expected 1 0", core_hold, drop_err);
    end
  endtask

  task automatic test_a78(input int plen, input int pbusy);
    logic [7:0] file [$];
    string s = "ATARI";
    int b_load = load_cnt, bad = 0;
    logic is7800;
    logic [31:0] exp_size;
    for (int i = 0; i < 128 + plen; i++) file.push_back(8'($urandom));
    for (int k = 0; k < 5; k++) file[1+k] = s[k];
    file[53] = 8'h12; file[54] = 8'h34;
    is7800 = ref_is7800(file);
    exp_size = ref_size(file.size(), is7800);
    cart_img.delete();
    start_dl(8'd1);
    for (int i = 0; i < file.size(); i++) begin
      send_byte(i, file[i], pbusy);
      if (i == 200) begin
        checks++;
        if (core_hold !== 1'b1) begin errors++; $display("FAIL a78_hold_mid: got %b expected 1", core_hold); end
      end
    end
    end_dl();
    checks++;
    if (cart_is_7800 !== is7800) begin errors++; $display("FAIL a78_is7800: got %b expected %b", cart_is_7800, is7800); end
    checks++;
    if (cart_flags !== {file[53], file[54]}) begin
      errors++; $display("FAIL a78_flags: got %h expected %h", cart_flags, {file[53], file[54]});
    end
    checks++;
    if ({joy0_type, joy1_type, cart_region, cart_save} !== {file[55], file[56], file[57], file[58]}) begin
      errors++; $display("FAIL a78_hdr: got %h expected %h", {joy0_type, joy1_type, cart_region, cart_save},
                         {file[55], file[56], file[57], file[58]});
    end
    for (int a = 0; a < plen; a++)
      if (!cart_img.exists(a) || cart_img[a] !== file[a+128]) bad++;
    checks++;
    if (bad !== 0 || cart_img.size() !== plen) begin
      errors++; $display("FAIL a78_image: got %0d bad of %0d entries expected 0 bad of %0d", bad, cart_img.size(), plen);
    end
    checks++;
    if (load_cnt - b_load !== 1) begin errors++; $display("FAIL a78_load_cnt: got %0d expected 1", load_cnt - b_load); end
    checks++;
    if (last_size !== exp_size || cart_size !== exp_size) begin
      errors++; $display("FAIL a78_size: got %0d/%0d expected %0d", last_size, cart_size, exp_size);
    end
    checks++;
    if (core_hold !== 1'b0 || drop_err !== 1'b0) begin
      errors++; $display("FAIL a78_end: got hold=%b drop=%b expected 0 0", core_hold, drop_err);
    end
  endtask

  task automatic test_raw();
    logic [7:0] file [$];
    int b_load = load_cnt, bad = 0;
    logic [31:0] exp_size;
    for (int i = 0; i < 4096; i++) file.push_back(8'($urandom));
    file[1] = 8'h00;
    exp_size = ref_size(file.size(), ref_is7800(file));
    cart_img.delete();
    start_dl(8'd7);
    for (int i = 0; i < file.size(); i++) send_byte(i, file[i], 30);
    end_dl();
    for (int a = 0; a < 4096; a++)
      if (!cart_img.exists(a) || cart_img[a] !== file[a]) bad++;
    checks++;
    if (bad !== 0 || cart_img.size() !== 4096) begin
      errors++; $display("FAIL raw_image: got %0d bad of %0d entries expected 0 bad of 4096", bad, cart_img.size());
    end
    checks++;
    if (cart_is_7800 !== 1'b0 || cart_flags !== {file[53], file[54]} || cart_save !== file[58]) begin
      errors++; $display("FAIL raw_hdr: got 7800=%b flags=%h save=%h expected 0 %h %h",
                         cart_is_7800, cart_flags, cart_save, {file[53], file[54]}, file[58]);
    end
    checks++;
    if (cart_size !== exp_size || load_cnt - b_load !== 1) begin
      errors++; $display("FAIL raw_size: got %0d loads=%0d expected %0d loads=1", cart_size, load_cnt - b_load, exp_size);
    end
  endtask

  task automatic test_stall();
    int b_load = load_cnt, waits = 0, ld_early = 0;
    cart_img.delete();
    start_dl(8'd2);
    mem_busy = 1'b0; ioctl_wr = 1'b1; ioctl_addr = 25'd10; ioctl_dout = 8'hA5;
    cyc();
    ioctl_wr = 1'b0; mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (ioctl_wait === 1'b1 && mem_addr === 18'd10 && mem_data === 8'hA5 && cart_we === 1'b1) waits++;
      ioctl_wr = (i == 2); ioctl_addr = 25'd11; ioctl_dout = 8'h5A;
      @(posedge clk_sys); #1;
    end
    ioctl_wr = 1'b0; mem_busy = 1'b0;
    #1;
    checks++;
    if (waits !== 5) begin errors++; $display("FAIL stall_wait: got %0d stable wait cycles expected 5", waits); end
    checks++;
    if (drop_err !== 1'b1) begin errors++; $display("FAIL stall_drop: got %b expected 1", drop_err); end
    cyc(); cyc();
    // falling edge with a stalled write in flight
    ioctl_wr = 1'b1; ioctl_addr = 25'd12; ioctl_dout = 8'h3C;
    cyc();
    ioctl_wr = 1'b0; mem_busy = 1'b1; ioctl_download = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (load_done !== 1'b0) ld_early++;
    end
    mem_busy = 1'b0;
    #1;
    if (load_done !== 1'b0) ld_early++;
    checks++;
    if (ld_early !== 0) begin errors++; $display("FAIL edge_early: got %0d early load_done cycles expected 0", ld_early); end
    cyc();
    checks++;
    if (load_done !== 1'b1 || cart_size !== 32'd13) begin
      errors++; $display("FAIL edge_done: got load_done=%b size=%0d expected 1 13", load_done, cart_size);
    end
    cyc();
    checks++;
    if (load_done !== 1'b0 || load_cnt - b_load !== 1) begin
      errors++; $display("FAIL edge_pulse: got load_done=%b loads=%0d expected 0 1", load_done, load_cnt - b_load);
    end
    checks++;
    if (cart_img.exists(11) || cart_img[10] !== 8'hA5 || cart_img[12] !== 8'h3C) begin
      errors++; $display("FAIL stall_image: got has11=%0d m10=%h m12=%h expected 0 a5 3c",
                         cart_img.exists(11), cart_img[10], cart_img[12]);
    end
  endtask

  task automatic test_overflow();
    string s = "ATARI";
    do_reset();
    cart_img.delete();
    start_dl(8'd3);
    for (int i = 0; i < 128; i++) begin
      logic [7:0] d = (i >= 1 && i <= 5) ? 8'(s[i-1]) : (i == 0 ? 8'h00 : 8'($urandom));
      send_byte(i, d, 0);
    end
    checks++;
    if (drop_err !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %b expected 0", drop_err); end
    send_byte(32'h4007F, 8'h11, 0);
    send_byte(32'h40080, 8'h22, 0);
    end_dl();
    checks++;
    if (drop_err !== 1'b1) begin errors++; $display("FAIL ovf_drop: got %b expected 1", drop_err); end
    checks++;
    if (cart_img[32'h3FFFF] !== 8'h11 || cart_img[0] !== 8'h00) begin
      errors++; $display("FAIL ovf_image: got top=%h m0=%h expected 11 00", cart_img[32'h3FFFF], cart_img[0]);
    end
    checks++;
    if (cart_size !== ref_size(32'h40081, 1'b1)) begin
      errors++; $display("FAIL ovf_size: got %h expected %h", cart_size, ref_size(32'h40081, 1'b1));
    end
  endtask

  task automatic test_reset_mid();
    string s = "ATARI";
    start_dl(8'd4);
    for (int i = 0; i < 200; i++) begin
      logic [7:0] d = (i >= 1 && i <= 5) ? 8'(s[i-1]) : ((i == 53 || i == 55) ? 8'hC3 : 8'($urandom));
      send_byte(i, d, 0);
    end
    mem_busy = 1'b0; ioctl_wr = 1'b1; ioctl_addr = 25'd200; ioctl_dout = 8'h77;
    cyc();
    ioctl_wr = 1'b0; mem_busy = 1'b1;
    cyc();
    reset_n = 1'b0; ioctl_download = 1'b0;
    cyc();
    checks++;
    if (core_hold !== 1'b1 || cart_we !== 1'b0 || bios_we !== 1'b0 || ioctl_wait !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctrl: got hold=%b we=%b/%b wait=%b expected 1 0/0 0", core_hold, cart_we, bios_we, ioctl_wait);
    end
    checks++;
    if (cart_flags !== 16'd0 || joy0_type !== 8'd0 || cart_is_7800 !== 1'b0 || cart_size !== 32'd0) begin
      errors++; $display("FAIL rstmid_hdr: got flags=%h joy0=%h 7800=%b size=%0d expected 0", cart_flags, joy0_type, cart_is_7800, cart_size);
    end
    reset_n = 1'b1; mem_busy = 1'b0;
    cyc();
    test_a78(2048, 20);
  endtask

  initial begin
    test_reset();
    test_bios();
    test_a78(32768, 0);
    test_raw();
    test_stall();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/a78_cart_loader.md
# a78_cart_loader

Download sequencer between the HPS ioctl stream and the Atari 7800 cart/BIOS dual-port RAMs. It classifies each download as BIOS (index 0) or cart (index ≠ 0), parses the 128-byte A78 header, strips it from the cart image, and issues stallable byte writes to the RAM write ports with ioctl_wait back-pressure. When the download ends it computes the cart size and releases the console hold.

## Interface
Parameters:
- CART_AW, 18, cart RAM address width (bytes at or above 2^CART_AW are dropped)
- BIOS_AW, 12, BIOS RAM address width
- HDR_LEN, 128, A78 header length stripped from 7800 images

Ports:
- clk_sys  in  1  sole clock
- reset_n  in  1  synchronous, active-low reset
- ioctl_download  in  1  download window
- ioctl_index  in  8  0 = BIOS, other = cart
- ioctl_wr  in  1  byte strobe, one cycle
- ioctl_addr  in  25  byte address within file
- ioctl_dout  in  8  byte data
- ioctl_wait  out  1  host must not strobe while high
- mem_busy  in  1  RAM write port stall
- cart_we  out  1  cart write valid
- bios_we  out  1  BIOS write valid
- mem_addr  out  CART_AW  write address (BIOS uses low BIOS_AW bits)
- mem_data  out  8  write data
- cart_is_7800  out  1  header bytes 1..5 equal "ATARI"
- cart_flags  out  16  header bytes 53,54
- joy0_type, joy1_type, cart_region, cart_save  out  8 each  header bytes 55..58
- cart_size  out  32  payload bytes of last cart
- core_hold  out  1  console held in reset
- load_done  out  1  one-cycle pulse at end of cart download
- drop_err  out  1  sticky: strobe lost or address overflow

## Operation
- States: IDLE, CART, BIOS, FINISH.
- IDLE → CART or BIOS on a cycle with ioctl_download=1, selected by ioctl_index. Entering CART clears every header field and cart_is_7800.
- CART/BIOS → FINISH on ioctl_download=0. FINISH waits until no write is pending. For CART, it then latches cart_size and pulses load_done, both in the same cycle, then goes to IDLE. For BIOS, it goes to IDLE with no pulse.
- Accepted strobe: ioctl_wr=1 in CART/BIOS while ioctl_wait=0. A strobe while ioctl_wait=1 is ignored and sets drop_err.
- Header capture applies to CART strobes only, from raw ioctl_addr:
  - Bytes 1..5 are compared against "ATARI".
  - Bytes 53/54 → cart_flags[15:8]/[7:0].
  - Bytes 55..58 → joy0_type, joy1_type, cart_region, cart_save.
  - Bytes 49..52 are ignored.
- Cart address: ioctl_addr − HDR_LEN when cart_is_7800 and ioctl_addr ≥ HDR_LEN; otherwise ioctl_addr. Header bytes are therefore written at 0..127 and later overwritten by the payload. This is intended.
- A translated address ≥ 2^CART_AW (cart) or ioctl_addr ≥ 2^BIOS_AW (BIOS) is not written and sets drop_err.
- cart_size = last accepted ioctl_addr + 1 − (cart_is_7800 ? HDR_LEN : 0), in 32-bit arithmetic and saturated at 0. With no accepted strobe, cart_size = 0.
- core_hold = 1 from reset until the first load_done. It is also 1 in CART and FINISH. A BIOS download does not release it.
- drop_err clears only on reset.

## Timing
- Reset values:
  - All outputs 0 except core_hold=1.
  - State IDLE.
  - Header fields, cart_size and drop_err 0.
  - No pending write.
- An accepted strobe in cycle N sets cart_we or bios_we, with mem_addr and mem_data, registered in N+1.
- A write completes in a cycle where we=1 and mem_busy=0. we deasserts the next cycle unless a new strobe was accepted in the completing cycle. Back-to-back writes every cycle are legal.
- While we=1 and mem_busy=1, mem_addr, mem_data and we are held stable.
- ioctl_wait = we & mem_busy, combinational.
- Download falling edge with a write pending: the write completes first. load_done comes 1 cycle after completion, or 1 cycle after the edge if nothing is pending.
- If ioctl_download falls and rises again before FINISH exits, the new download starts from IDLE on the cycle after FINISH.
- reset_n low mid-download aborts immediately. A pending write is discarded and all reset values are restored.

## Test plan
- BIOS: index 0, 4096 strobes with data = addr[7:0] → bios_we×4096 with mem_addr = addr. No load_done. core_hold stays 1.
- A78 cart: 128-byte header "ATARI" at 1..5, byte 53 = 0x12, byte 54 = 0x34, then 32768 payload bytes → cart_is_7800 = 1, cart_flags = 0x1234, payload written at 0..32767, cart_size = 32768, one load_done, core_hold → 0.
- Raw cart of 4096 bytes with no header → every byte at mem_addr = ioctl_addr, cart_size = 4096.
- Stall: mem_busy high for 5 cycles during a write → ioctl_wait high 5 cycles with addr/data stable. A strobe injected during the stall sets drop_err and that byte is not written.
- Falling edge with a stalled write pending → load_done exactly 1 cycle after mem_busy drops. Overflow byte at translated address 0x40000 → dropped, drop_err = 1.
- reset_n low mid-cart download → core_hold = 1, we = 0, header fields 0. A following complete download behaves as in the second scenario.
